// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - TD4 run/halt/step controller: clock-enable, core reset, breakpoint, program-write arbitration
// Optional PC-stall watchdog is built when TD4_RUN_CTRL_WDOG_EN is defined.
module td4_run_ctrl #(
   parameter int CNT_W    = 16,
   parameter int RST_HOLD = 2,
   parameter int WDOG_LIM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   output logic             cmd_ready,
   input  logic [3:0]       pc_addr,
   output logic             core_ce,
   output logic             core_rst,
   input  logic             bp_en,
   input  logic [3:0]       bp_addr,
   input  logic             hw_valid,
   input  logic [3:0]       hw_addr,
   input  logic [7:0]       hw_data,
   output logic             hw_ready,
   output logic             mem_we,
   output logic [3:0]       mem_waddr,
   output logic [7:0]       mem_wdata,
   output logic [1:0]       state,
   output logic             step_done,
   output logic             bp_flag,
   output logic             wdog_flag,
   output logic [CNT_W-1:0] icount
);
   localparam logic [1:0] ST_HALT = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_STEP = 2'b10;
   localparam logic [1:0] ST_CRST = 2'b11;

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_HALT  = 2'b10;
   localparam logic [1:0] OP_STEP  = 2'b11;

   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);

   logic [1:0]        state_d;
   logic [HOLD_W-1:0] hold_cnt;
   logic              skip;
   logic              cmd_acc;
   logic              hw_acc;
   logic              bp_match;
   logic              bp_hit;
   logic              rst_cmd;
   logic              flag_clr;
   logic              wdog_fire;

   assign cmd_acc  = cmd_valid && cmd_ready;
   assign hw_acc   = hw_valid && hw_ready;
   assign bp_match = bp_en && (pc_addr == bp_addr);
   // skip lets the instruction we halted on execute once when resuming
   assign bp_hit   = (state == ST_RUN) && bp_match && !skip;
   assign rst_cmd  = cmd_acc && (cmd_op == OP_RESET);
   assign flag_clr = cmd_acc && (cmd_op != OP_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CRST;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_CRST: begin
            if (hold_cnt == HOLD_LAST) state_d = ST_HALT;
         end
         ST_HALT: begin
            if (cmd_acc) begin
               case (cmd_op)
                  OP_RUN:   state_d = ST_RUN;
                  OP_STEP:  state_d = ST_STEP;
                  OP_RESET: state_d = ST_CRST;
                  default:  state_d = ST_HALT;
               endcase
            end
         end
         ST_RUN: begin
            if (rst_cmd) begin
               state_d = ST_CRST;
            end else if (bp_hit || wdog_fire || (cmd_acc && cmd_op == OP_HALT)) begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   // RESET in RUN must not let the core advance in its accept cycle
   always_comb begin
      core_ce   = 1'b0;
      core_rst  = 1'b0;
      cmd_ready = 1'b0;
      hw_ready  = 1'b0;
      case (state)
         ST_HALT: begin
            cmd_ready = 1'b1;
            hw_ready  = 1'b1;
         end
         ST_RUN: begin
            cmd_ready = 1'b1;
            core_ce   = !bp_hit && !(cmd_valid && cmd_op == OP_RESET);
         end
         ST_STEP: core_ce  = 1'b1;
         default: core_rst = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= HOLD_INIT;
      end else if (rst_cmd) begin
         hold_cnt <= HOLD_INIT;
      end else if (state == ST_CRST && hold_cnt != HOLD_LAST) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skip      <= 1'b0;
         bp_flag   <= 1'b0;
         step_done <= 1'b0;
         icount    <= '0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         step_done <= (state == ST_STEP);
         mem_we    <= hw_acc;
         if (hw_acc) begin
            mem_waddr <= hw_addr;
            mem_wdata <= hw_data;
         end
         if (rst_cmd) begin
            icount <= '0;
         end else if (core_ce && icount != '1) begin
            icount <= icount + 1'b1;
         end
         if (rst_cmd) begin
            bp_flag <= 1'b0;
         end else if (bp_hit) begin
            bp_flag <= 1'b1;
         end else if (flag_clr) begin
            bp_flag <= 1'b0;
         end
         if (state == ST_HALT && cmd_acc && cmd_op == OP_RUN) begin
            skip <= bp_match;
         end else if (state != ST_RUN || core_ce) begin
            skip <= 1'b0;
         end
      end
   end

`ifdef TD4_RUN_CTRL_WDOG_EN
   localparam int WD_W = $clog2(WDOG_LIM + 1);

   logic [WD_W-1:0] wd_cnt;
   logic [3:0]      wd_pc;
   logic            wd_pc_vld;
   logic            wd_same;

   // a JMP-to-self keeps presenting the same PC on every enabled cycle
   assign wd_same   = core_ce && (state == ST_RUN) && wd_pc_vld && (pc_addr == wd_pc);
   assign wdog_fire = wd_same && (wd_cnt == WD_W'(WDOG_LIM - 1));

   always_ff @(posedge clk) begin
      if (rst || state != ST_RUN) begin
         wd_cnt    <= '0;
         wd_pc     <= '0;
         wd_pc_vld <= 1'b0;
      end else if (core_ce) begin
         wd_pc     <= pc_addr;
         wd_pc_vld <= 1'b1;
         wd_cnt    <= wd_same ? wd_cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || rst_cmd) begin
         wdog_flag <= 1'b0;
      end else if (wdog_fire && !bp_hit) begin
         wdog_flag <= 1'b1;
      end else if (flag_clr) begin
         wdog_flag <= 1'b0;
      end
   end
`else
   assign wdog_fire = 1'b0 && (WDOG_LIM > 0);
   assign wdog_flag = wdog_fire;
`endif

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - scoreboard bench for td4_run_ctrl with a simple incrementing-PC core model
module tb_td4_run_ctrl;
   localparam logic [1:0] ST_HALT = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_STEP = 2'b10;
   localparam logic [1:0] ST_CRST = 2'b11;
   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_HALT  = 2'b10;
   localparam logic [1:0] OP_STEP  = 2'b11;

   typedef struct packed {
      logic        sd;
      logic        bpf;
      logic        wdf;
      logic [15:0] ic;
      logic [3:0]  pc;
   } halt_ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        cmd_ready;
   logic [3:0]  pc = 4'd0;
   logic        core_ce;
   logic        core_rst;
   logic        bp_en;
   logic [3:0]  bp_addr;
   logic        hw_valid;
   logic [3:0]  hw_addr;
   logic [7:0]  hw_data;
   logic        hw_ready;
   logic        mem_we;
   logic [3:0]  mem_waddr;
   logic [7:0]  mem_wdata;
   logic [1:0]  state;
   logic        step_done;
   logic        bp_flag;
   logic        wdog_flag;
   logic [15:0] icount;

   logic        self_loop = 1'b0;
   logic [1:0]  prev_state = ST_CRST;
   int          ce_cnt = 0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [11:0] wr_q[$];
   halt_ev_t    halt_q[$];

   td4_run_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .pc_addr(pc), .core_ce(core_ce), .core_rst(core_rst), .bp_en(bp_en), .bp_addr(bp_addr),
      .hw_valid(hw_valid), .hw_addr(hw_addr), .hw_data(hw_data), .hw_ready(hw_ready),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .state(state),
      .step_done(step_done), .bp_flag(bp_flag), .wdog_flag(wdog_flag), .icount(icount)
   );

   always #5 clk = ~clk;

   // core model: PC advances on each enabled cycle; optional JMP 7 at address 7
   always @(posedge clk) begin
      if (core_rst) pc <= 4'd0;
      else if (core_ce) pc <= (self_loop && pc == 4'd7) ? 4'd7 : pc + 4'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            if (wr_q.size() == 0) begin
               chk("mem_we_unexpected", {31'd0, mem_we}, 32'd0);
            end else begin
               logic [11:0] ew;
               ew = wr_q.pop_front();
               chk("mem_write", {20'd0, mem_waddr, mem_wdata}, {20'd0, ew});
            end
         end
         if (state == ST_HALT && (prev_state == ST_RUN || prev_state == ST_STEP)) begin
            if (halt_q.size() == 0) begin
               chk("halt_unexpected", {30'd0, prev_state}, 32'd0);
            end else begin
               halt_ev_t eh;
               eh = halt_q.pop_front();
               chk("halt_event{sd,bpf,wdf,ic,pc}",
                   {9'd0, step_done, bp_flag, wdog_flag, icount, pc}, {9'd0, eh});
            end
         end
         if (core_ce) ce_cnt++;
      end
      prev_state = state;
   end

   task automatic issue_cmd(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] exp, input int max, input string name);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (state == exp) break;
      end
      chk(name, {30'd0, state}, {30'd0, exp});
   endtask

   task automatic count_rst(output int n);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!core_rst) break;
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got state 0x%0h expected finish", state);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int ce0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HALT; bp_en = 1'b0; bp_addr = 4'd0;
      hw_valid = 1'b0; hw_addr = 4'd0; hw_data = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", {30'd0, state}, {30'd0, ST_CRST});
      chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
      chk("rst_core_ce", {31'd0, core_ce}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_hw_ready", {31'd0, hw_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_rst(n);
      chk("rst_hold_cycles", n, 32'd2);
      chk("halt_state", {30'd0, state}, {30'd0, ST_HALT});
      chk("halt_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("halt_hw_ready", {31'd0, hw_ready}, 32'd1);
      chk("rst_icount", {16'd0, icount}, 32'd0);
      chk("rst_flags", {30'd0, bp_flag, wdog_flag}, 32'd0);
      chk("rst_step_done", {31'd0, step_done}, 32'd0);
      @(posedge clk); #1;

      // host write while halted
      hw_valid = 1'b1; hw_addr = 4'd3; hw_data = 8'hB5;
      wr_q.push_back({4'd3, 8'hB5});
      @(posedge clk); #1;
      hw_valid = 1'b0;
      repeat (2) @(posedge clk); #1;

      // single step
      ce0 = ce_cnt;
      halt_q.push_back('{sd: 1'b1, bpf: 1'b0, wdf: 1'b0, ic: 16'd1, pc: 4'd1});
      issue_cmd(OP_STEP);
      wait_state(ST_HALT, 5, "step_returns_halt");
      chk("step_ce_cycles", ce_cnt - ce0, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("step_done_pulse_end", {31'd0, step_done}, 32'd0);
      @(posedge clk); #1;

      // RESET from HALT brings PC and icount back to 0
      issue_cmd(OP_RESET);
      wait_state(ST_HALT, 10, "reset_returns_halt");
      chk("reset_icount", {16'd0, icount}, 32'd0);
      @(posedge clk); #1;

      // breakpoint at 5 from pc 0
      bp_en = 1'b1; bp_addr = 4'd5;
      halt_q.push_back('{sd: 1'b0, bpf: 1'b1, wdf: 1'b0, ic: 16'd5, pc: 4'd5});
      issue_cmd(OP_RUN);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (state == ST_RUN && pc == 4'd5) break;
      end
      chk("bp_cycle_core_ce", {31'd0, core_ce}, 32'd0);
      wait_state(ST_HALT, 3, "bp_halts");
      @(posedge clk); #1;

      // resume executes the breakpointed instruction, then wraps back to 5
      halt_q.push_back('{sd: 1'b0, bpf: 1'b1, wdf: 1'b0, ic: 16'd21, pc: 4'd5});
      issue_cmd(OP_RUN);
      @(negedge clk);
      chk("resume_core_ce", {31'd0, core_ce}, 32'd1);
      chk("run_clears_bp_flag", {31'd0, bp_flag}, 32'd0);
      @(posedge clk); #1;
      chk("resume_pc_advances", {28'd0, pc}, 32'd6);
      wait_state(ST_HALT, 40, "bp_wrap_halts");
      @(posedge clk); #1;

      // HALT command coinciding with a breakpoint hit
      bp_addr = 4'd8;
      halt_q.push_back('{sd: 1'b0, bpf: 1'b1, wdf: 1'b0, ic: 16'd24, pc: 4'd8});
      issue_cmd(OP_RUN);
      for (int i = 0; i < 20; i++) begin
         if (pc == 4'd8) break;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b1; cmd_op = OP_HALT;
      @(negedge clk);
      chk("halt_bp_same_core_ce", {31'd0, core_ce}, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("halt_bp_same_state", {30'd0, state}, {30'd0, ST_HALT});
      chk("halt_bp_same_flag", {31'd0, bp_flag}, 32'd1);
      @(posedge clk); #1;

      // write accepted with RUN, blocked write in RUN, RESET while running
      bp_en = 1'b0;
      hw_valid = 1'b1; hw_addr = 4'd9; hw_data = 8'h3C;
      wr_q.push_back({4'd9, 8'h3C});
      cmd_valid = 1'b1; cmd_op = OP_RUN;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      hw_addr = 4'd3; hw_data = 8'hB5;
      @(negedge clk);
      chk("run_hw_ready", {31'd0, hw_ready}, 32'd0);
      @(posedge clk); #1;
      hw_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = OP_RESET;
      @(negedge clk);
      chk("run_reset_accept_ce", {31'd0, core_ce}, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      count_rst(n);
      chk("run_reset_hold_cycles", n, 32'd2);
      chk("run_reset_icount", {16'd0, icount}, 32'd0);
      chk("run_reset_flags", {30'd0, bp_flag, wdog_flag}, 32'd0);
      chk("run_reset_state", {30'd0, state}, {30'd0, ST_HALT});
      @(posedge clk); #1;

      // JMP-to-self at address 7
      self_loop = 1'b1;
`ifdef TD4_RUN_CTRL_WDOG_EN
      halt_q.push_back('{sd: 1'b0, bpf: 1'b0, wdf: 1'b1, ic: 16'd16, pc: 4'd7});
      issue_cmd(OP_RUN);
      wait_state(ST_HALT, 40, "wdog_halts");
      @(posedge clk); #1;
`else
      halt_q.push_back('{sd: 1'b0, bpf: 1'b0, wdf: 1'b0, ic: 16'hFFFF, pc: 4'd7});
      issue_cmd(OP_RUN);
      repeat (65600) @(posedge clk);
      #1;
      @(negedge clk);
      chk("no_wdog_still_running", {30'd0, state}, {30'd0, ST_RUN});
      chk("no_wdog_flag", {31'd0, wdog_flag}, 32'd0);
      chk("icount_saturates", {16'd0, icount}, 32'h0000FFFF);
      @(posedge clk); #1;
      issue_cmd(OP_HALT);
      wait_state(ST_HALT, 3, "halt_after_loop");
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("wr_q_drained", wr_q.size(), 32'd0);
      chk("halt_q_drained", halt_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/td4_run_ctrl.md
Name: td4_run_ctrl

Overview:
- Run/halt/step controller for the TD4 4-bit CPU core.
- Gates the core through a clock-enable, drives the core's synchronous reset, and stops the core on a PC breakpoint.
- Arbitrates the 16x8 program RAM write port, so the host may load code only while the core is halted.
- Sits between the host/debug interface and the TD4 core plus program RAM.

Parameters:
- CNT_W, 16, width of the executed-instruction counter.
- RST_HOLD, 2, number of cycles core_rst is held high on reset or on a RESET command (≥1).
- WDOG_LIM, 8, consecutive enabled cycles with an unchanged PC before the watchdog fires (only with the macro).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command strobe.
- cmd_op  in  2  command: 00 RESET, 01 RUN, 10 HALT, 11 STEP.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- pc_addr  in  4  current core PC (program address).
- core_ce  out  1  core clock-enable.
- core_rst  out  1  core reset, active-high.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  4  breakpoint address.
- hw_valid  in  1  host program-write request.
- hw_addr  in  4  host write address.
- hw_data  in  8  host write data.
- hw_ready  out  1  host write accepted.
- mem_we  out  1  program RAM write enable.
- mem_waddr  out  4  program RAM write address.
- mem_wdata  out  8  program RAM write data.
- state  out  2  state: 00 HALT, 01 RUN, 10 STEP, 11 CRST.
- step_done  out  1  one-cycle pulse when a STEP completes.
- bp_flag  out  1  sticky: halted by breakpoint.
- wdog_flag  out  1  sticky: halted by watchdog.
- icount  out  CNT_W  count of core_ce-high cycles.

Behaviour:
- rst (synchronous):
  - state=CRST, hold counter=RST_HOLD, core_rst=1, core_ce=0.
  - cmd_ready=0, hw_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0.
  - step_done=0, bp_flag=0, wdog_flag=0, icount=0, skip=0.
- CRST:
  - core_rst=1, core_ce=0, cmd_ready=0.
  - Hold counter decrements each cycle; when it reaches 1, next state is HALT.
  - core_rst is therefore high for exactly RST_HOLD cycles after rst deasserts.
- HALT:
  - core_ce=0, cmd_ready=1, hw_ready=1.
  - RUN → RUN; skip set if bp_en && pc_addr==bp_addr, so the breakpointed instruction can execute once.
  - STEP → STEP.
  - RESET → CRST, reload hold counter, clear icount.
  - HALT → no-op.
  - Any accepted RUN, STEP or RESET clears bp_flag and wdog_flag.
- RUN:
  - bp_hit = bp_en && pc_addr==bp_addr && !skip.
  - core_ce = !bp_hit (combinational).
  - skip clears after the first core_ce=1 cycle.
  - bp_hit → HALT with core_ce=0 that cycle, so the instruction at bp_addr is not executed; set bp_flag.
  - cmd_ready=1, hw_ready=0.
  - HALT cmd → HALT; core_ce is still 1 in the accept cycle.
  - RESET cmd → CRST; core_ce=0 in the accept cycle.
  - RUN or STEP cmd → accepted, ignored.
- STEP:
  - core_ce=1 for exactly one cycle, then HALT.
  - step_done=1 on the first HALT cycle.
  - Breakpoint is ignored during STEP.
  - cmd_ready=0, hw_ready=0.
- Simultaneous events in RUN:
  - RESET cmd beats bp_hit; flags are cleared.
  - HALT cmd and bp_hit together → HALT, bp_flag=1, core_ce=0.
- Host write:
  - Accepted when hw_valid && hw_ready.
  - mem_we/mem_waddr/mem_wdata are registered; mem_we=1 exactly one cycle after accept, 0 otherwise.
  - A write accepted in the same cycle as a RUN command still completes. The RAM write lands one cycle later, in parallel with the core's first fetch cycle; the host is responsible for not overwriting the word at the current PC.
- icount:
  - +1 on every core_ce=1 cycle.
  - Saturates at all-ones, no wrap.
  - Cleared by rst or an accepted RESET.

Optional Feature:
- Macro: TD4_RUN_CTRL_WDOG_EN.
- With the macro: in RUN, a counter increments on each core_ce cycle where pc_addr equals its value from the previous enabled cycle.
  - This catches the TD4 JMP-to-self idiom.
  - The counter resets on any PC change or on leaving RUN.
  - On reaching WDOG_LIM: force HALT next cycle, set wdog_flag.
  - Breakpoint takes priority when both fire in the same cycle.
- Without the macro: no watchdog logic; wdog_flag tied 0.

Test Plan:
- Release rst → core_rst=1 for 2 cycles, state 11→00, cmd_ready=1, all flags and icount=0.
- In HALT, host writes addr 3=0xB5 → mem_we=1, mem_waddr=3, mem_wdata=0xB5 one cycle later.
  - Same write attempted in RUN → hw_ready=0, no mem_we.
- STEP from HALT → core_ce high exactly 1 cycle, step_done pulse, icount=1, state=00.
- bp_en=1, bp_addr=5, RUN from pc 0 → halts with pc_addr=5, core_ce=0 that cycle, bp_flag=1, icount=5.
  - Resuming with RUN → instruction at 5 executes, pc advances.
- RUN, then HALT and bp_hit in the same cycle → state=00, bp_flag=1.
  - RESET during RUN → core_rst 2 cycles, icount=0, flags cleared.
- With TD4_RUN_CTRL_WDOG_EN: program JMP 7 at addr 7 → after 8 cycles at pc 7, state=00, wdog_flag=1.
  - Without the macro → core keeps running, wdog_flag=0.
